lcrc_tx_seq_ctrl: RTL and testbench
===================================

// Module: lcrc_tx_seq_ctrl
// PURPOSE
//  Data-link-layer TX sequencer: wraps each incoming TLP with a sequence-number header dword and a trailing LCRC dword.
//  Sits between transaction-layer TX stream and the replay buffer write port; drives the 32-bit LCRC datapath dword-by-dword.
//  Owns NEXT_TRANSMIT_SEQ; stalls new TLPs while the replay buffer reports full.
// PARAMETERS
//  SEQ_WIDTH  12            sequence number width; wraps (2**SEQ_WIDTH-1) -> 0
//  CRC_POLY   32'h04C11DB7  LCRC generator polynomial, MSB-first
//  CRC_INIT   32'hFFFFFFFF  CRC seed loaded at each header dword
//  MAX_DW     1024          max TLP payload+header dwords before len_err
// PORTS
//  clk        in   1   clock, all state on rising edge
//  reset      in   1   asynchronous, active-low reset
//  tlp_valid  in   1   input dword valid
//  tlp_ready  out  1   input dword accepted when tlp_valid&tlp_ready
//  tlp_data   in   32  TLP dword
//  tlp_sop    in   1   first dword of TLP
//  tlp_eop    in   1   last dword of TLP
//  rb_full    in   1   replay buffer cannot accept a new TLP
//  out_valid  out  1   framed dword valid
//  out_ready  in   1   downstream/replay buffer accepts dword
//  out_data   out  32  framed dword (header, TLP, LCRC)
//  out_sop    out  1   marks header dword
//  out_eop    out  1   marks LCRC dword
//  next_seq   out  SEQ_WIDTH  sequence number for next TLP
//  len_err    out  1   1-cycle pulse: TLP exceeded MAX_DW
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, next_seq=0, crc=CRC_INIT, dw_cnt=0; tlp_ready, out_valid, out_sop, out_eop, len_err=0; out_data=0.
//  FSM IDLE: waits tlp_valid&tlp_sop&!rb_full -> HDR (TLP dword not consumed). tlp_valid without sop in IDLE: dropped (tlp_ready=1).
//  HDR: out_data={{(32-SEQ_WIDTH){1'b0}},next_seq}, out_sop=1; on out_ready: crc=step(CRC_INIT,hdr) -> DATA.
//  DATA: pass-through, tlp_ready=out_ready, out_valid=tlp_valid; per accepted dword crc=step(crc,data), dw_cnt++.
//   accepted tlp_eop -> LCRC. dw_cnt reaching MAX_DW without eop: len_err pulse, framing continues.
//  LCRC: out_data=~crc, out_eop=1; on out_ready: next_seq<=next_seq+1 (mod 2**SEQ_WIDTH), dw_cnt=0 -> IDLE.
//  Latency: header appears cycle after sop seen in IDLE; data zero-cycle pass-through; LCRC 1 cycle after eop accept.
//  Stall rule: out_valid, once high, holds with out_data/sop/eop stable until out_ready. tlp_ready never high in IDLE-accept, HDR or LCRC.
//  rb_full only checked in IDLE; asserting mid-TLP does not interrupt the frame.
//  tlp_sop in DATA (no preceding eop): treated as data, no restart.
//  Single-dword TLP (sop&eop): HDR -> DATA (1 dword) -> LCRC, 3 output dwords.
//  step(): 32 serial shifts MSB-first over dword, poly CRC_POLY; combinational.
//  Reset mid-frame: all state cleared immediately, partial frame abandoned, next_seq=0.
// CONFIGURATION
//  LCRC_NULLIFY_EN defined: extra port tlp_nullify in 1, sampled with accepted tlp_eop.
//   nullify=1: LCRC dword = crc (not inverted), next_seq NOT incremented.
//  Undefined: port absent, LCRC always ~crc, next_seq always increments.
// STRUCTURE
//  lcrc_pkg: state enum {IDLE,HDR,DATA,LCRC}, CRC_POLY/CRC_INIT defaults, header-dword layout constant.
//  Sub-module lcrc_dw_step: combinational crc_out=step(crc_in,data_in); one instance.
// TESTING
//  1. Reset, one 4-dword TLP, out_ready=1 -> 6 dwords; header=32'h0000_0000; LCRC=~crc of model; next_seq=1.
//  2. 4096 single-dword TLPs -> header seq 0..4095 then 0 (wrap); next_seq=1 after 4097th.
//  3. out_ready random 50% -> out_data/sop/eop stable while stalled; output sequence identical to test 1.
//  4. rb_full=1 with sop waiting -> no header, tlp_ready=0; drop rb_full -> header next cycle.
//  5. reset pulse during DATA dword 2 -> all outputs 0, next_seq=0; following TLP framed with seq 0.
//  6. LCRC_NULLIFY_EN, nullify=1 on TLP seq 5 -> LCRC=crc uninverted, next TLP also uses seq 5.

Source files
------------

// File: rtl/lcrc_pkg.sv
// ---------------------------------------------------------------------------
// lcrc_pkg
//   Shared definitions for the data-link-layer TX sequencer:
//   - lcrc_state_e : framing FSM states (IDLE, HDR, DATA, LCRC)
//   - LCRC_POLY_DEFAULT / LCRC_INIT_DEFAULT : default LCRC polynomial and seed
//   - HDR_SEQ_LSB / make_hdr_dword : layout of the sequence-number header dword
//   - crc_bit_step : one MSB-first serial shift of the LCRC register
//   No ports (package).
// ---------------------------------------------------------------------------
package lcrc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    LCRC = 2'd3
  } lcrc_state_e;

  localparam logic [31:0] LCRC_POLY_DEFAULT = 32'h04C11DB7;
  localparam logic [31:0] LCRC_INIT_DEFAULT = 32'hFFFFFFFF;

  // Header dword: sequence number right-aligned, all upper bits reserved zero.
  localparam int HDR_SEQ_LSB = 0;

  function automatic logic [31:0] make_hdr_dword(input logic [31:0] seq_ext);
    return seq_ext << HDR_SEQ_LSB;
  endfunction

  // One serial CRC shift: feedback is the register MSB xor the incoming bit.
  function automatic logic [31:0] crc_bit_step(input logic [31:0] crc,
                                               input logic        din,
                                               input logic [31:0] poly);
    return {crc[30:0], 1'b0} ^ (((crc[31] ^ din) == 1'b1) ? poly : 32'h0);
  endfunction

endpackage

// File: rtl/lcrc_dw_step.sv
// ---------------------------------------------------------------------------
// lcrc_dw_step
//   Combinational LCRC update over one 32-bit dword: 32 serial shifts,
//   data bit 31 first.
//   Parameters: POLY  generator polynomial (MSB-first form)
//   Ports:
//     crc_in   in  32  current CRC register
//     data_in  in  32  dword being folded in
//     crc_out  out 32  CRC after all 32 bits of data_in
// ---------------------------------------------------------------------------
module lcrc_dw_step
  import lcrc_pkg::*;
#(
  parameter logic [31:0] POLY = LCRC_POLY_DEFAULT
) (
  input  logic [31:0] crc_in,
  input  logic [31:0] data_in,
  output logic [31:0] crc_out
);

  logic [31:0] crc_acc;

  always_comb begin
    crc_acc = crc_in;
    for (int i = 31; i >= 0; i--) begin
      crc_acc = crc_bit_step(crc_acc, data_in[i], POLY);
    end
  end

  assign crc_out = crc_acc;

endmodule

// File: rtl/lcrc_tx_seq_ctrl.sv
// ---------------------------------------------------------------------------
// lcrc_tx_seq_ctrl
//   Data-link-layer TX sequencer. Wraps each TLP from the transaction layer
//   with a leading sequence-number header dword and a trailing LCRC dword,
//   and owns NEXT_TRANSMIT_SEQ. New TLPs are held off while the replay
//   buffer reports full; a frame already started always completes.
//
//   Optional feature macro: LCRC_NULLIFY_EN
//     defined   -> extra input tlp_nullify, sampled with the accepted eop
//                  dword; a nullified TLP gets an uninverted LCRC and does
//                  not consume a sequence number.
//     undefined -> port absent, LCRC always inverted, seq always advances.
//
//   Parameters: SEQ_WIDTH, CRC_POLY, CRC_INIT, MAX_DW
//   Ports:
//     clk          in   1          clock, all state on rising edge
//     reset        in   1          asynchronous active-low reset
//     tlp_valid    in   1          input dword valid
//     tlp_ready    out  1          input dword accepted when valid&ready
//     tlp_data     in   32         TLP dword
//     tlp_sop      in   1          first dword of TLP
//     tlp_eop      in   1          last dword of TLP
//     tlp_nullify  in   1          (LCRC_NULLIFY_EN only) nullify this TLP
//     rb_full      in   1          replay buffer cannot take a new TLP
//     out_valid    out  1          framed dword valid
//     out_ready    in   1          downstream accepts dword
//     out_data     out  32         framed dword (header, TLP, LCRC)
//     out_sop      out  1          marks header dword
//     out_eop      out  1          marks LCRC dword
//     next_seq     out  SEQ_WIDTH  sequence number for next TLP
//     len_err      out  1          1-cycle pulse: TLP exceeded MAX_DW dwords
// ---------------------------------------------------------------------------
module lcrc_tx_seq_ctrl
  import lcrc_pkg::*;
#(
  parameter int          SEQ_WIDTH = 12,
  parameter logic [31:0] CRC_POLY  = LCRC_POLY_DEFAULT,
  parameter logic [31:0] CRC_INIT  = LCRC_INIT_DEFAULT,
  parameter int          MAX_DW    = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tlp_valid,
  output logic                 tlp_ready,
  input  logic [31:0]          tlp_data,
  input  logic                 tlp_sop,
  input  logic                 tlp_eop,
`ifdef LCRC_NULLIFY_EN
  input  logic                 tlp_nullify,
`endif
  input  logic                 rb_full,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [SEQ_WIDTH-1:0] next_seq,
  output logic                 len_err
);

  // Counter saturates at MAX_DW, so it needs room for that value itself.
  localparam int CNT_W = $clog2(MAX_DW + 1);

  lcrc_state_e          state_reg, state_next;
  logic [SEQ_WIDTH-1:0] next_seq_reg;
  logic [31:0]          crc_reg;
  logic [CNT_W-1:0]     dw_cnt_reg;
  logic                 len_err_reg;
  logic                 lcrc_nullify;

  logic [31:0] hdr_dword;
  logic [31:0] step_crc_in;
  logic [31:0] step_data_in;
  logic [31:0] step_crc_out;
  logic        in_fire;

  assign hdr_dword = make_hdr_dword(32'(next_seq_reg));
  assign in_fire   = tlp_valid & tlp_ready;

  // The single step unit is shared: in HDR it seeds the CRC from the header,
  // in DATA it folds each accepted TLP dword into the running value.
  assign step_crc_in  = (state_reg == HDR) ? CRC_INIT  : crc_reg;
  assign step_data_in = (state_reg == HDR) ? hdr_dword : tlp_data;

  lcrc_dw_step #(
    .POLY (CRC_POLY)
  ) u_dw_step (
    .crc_in  (step_crc_in),
    .data_in (step_data_in),
    .crc_out (step_crc_out)
  );

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        // rb_full only gates the start of a frame.
        if (tlp_valid && tlp_sop && !rb_full) begin
          state_next = HDR;
        end
      end
      HDR: begin
        if (out_ready) begin
          state_next = DATA;
        end
      end
      DATA: begin
        // A stray sop here is just data; only an accepted eop ends the TLP.
        if (in_fire && tlp_eop) begin
          state_next = LCRC;
        end
      end
      LCRC: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    tlp_ready = 1'b0;
    out_valid = 1'b0;
    out_data  = 32'h0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    case (state_reg)
      IDLE: begin
        // Orphan dwords (no sop) are swallowed; a sop dword is left waiting
        // so it can be re-presented once the header has gone out.
        tlp_ready = tlp_valid & ~tlp_sop;
      end
      HDR: begin
        out_valid = 1'b1;
        out_sop   = 1'b1;
        out_data  = hdr_dword;
      end
      DATA: begin
        tlp_ready = out_ready;
        out_valid = tlp_valid;
        out_data  = tlp_data;
      end
      LCRC: begin
        out_valid = 1'b1;
        out_eop   = 1'b1;
        out_data  = lcrc_nullify ? crc_reg : ~crc_reg;
      end
      default: begin
        tlp_ready = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: running CRC, dword counter, sequence number, length error
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc_reg      <= CRC_INIT;
      dw_cnt_reg   <= '0;
      next_seq_reg <= '0;
      len_err_reg  <= 1'b0;
    end else begin
      len_err_reg <= 1'b0;
      case (state_reg)
        HDR: begin
          if (out_ready) begin
            crc_reg <= step_crc_out;
          end
        end
        DATA: begin
          if (in_fire) begin
            crc_reg <= step_crc_out;
            if (dw_cnt_reg != CNT_W'(MAX_DW)) begin
              dw_cnt_reg <= dw_cnt_reg + CNT_W'(1);
            end
            // Fires once, on the dword that fills the limit while the TLP
            // is still open; the frame itself carries on untouched.
            if (!tlp_eop && dw_cnt_reg == CNT_W'(MAX_DW - 1)) begin
              len_err_reg <= 1'b1;
            end
          end
        end
        LCRC: begin
          if (out_ready) begin
            crc_reg    <= CRC_INIT;
            dw_cnt_reg <= '0;
            if (!lcrc_nullify) begin
              next_seq_reg <= next_seq_reg + SEQ_WIDTH'(1);
            end
          end
        end
        default: begin
          crc_reg <= crc_reg;
        end
      endcase
    end
  end

`ifdef LCRC_NULLIFY_EN
  logic nullify_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nullify_reg <= 1'b0;
    end else if (state_reg == DATA && in_fire && tlp_eop) begin
      nullify_reg <= tlp_nullify;
    end
  end

  assign lcrc_nullify = nullify_reg;
`else
  assign lcrc_nullify = 1'b0;
`endif

  assign next_seq = next_seq_reg;
  assign len_err  = len_err_reg;

endmodule

// File: tb/tb_lcrc_tx_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcrc_tx_seq_ctrl
//   Directed bench for lcrc_tx_seq_ctrl. The DUT is built with MAX_DW=8 so
//   the length-limit boundary is reachable with short TLPs. Frames are
//   collected from the output handshake and compared against a CRC model.
//   Nullify steps run only when LCRC_NULLIFY_EN is defined.
// ---------------------------------------------------------------------------
module tb_lcrc_tx_seq_ctrl;

  localparam int          SEQ_W  = 12;
  localparam int          MAX_DW = 8;
  localparam logic [31:0] POLY   = 32'h04C11DB7;
  localparam logic [31:0] INIT   = 32'hFFFFFFFF;

  logic             clk = 1'b0;
  logic             reset;
  logic             tlp_valid;
  logic             tlp_ready;
  logic [31:0]      tlp_data;
  logic             tlp_sop;
  logic             tlp_eop;
`ifdef LCRC_NULLIFY_EN
  logic             tlp_nullify;
`endif
  logic             rb_full;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_sop;
  logic             out_eop;
  logic [SEQ_W-1:0] next_seq;
  logic             len_err;

  always #5 clk = ~clk;

  lcrc_tx_seq_ctrl #(
    .SEQ_WIDTH (SEQ_W),
    .CRC_POLY  (POLY),
    .CRC_INIT  (INIT),
    .MAX_DW    (MAX_DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tlp_valid   (tlp_valid),
    .tlp_ready   (tlp_ready),
    .tlp_data    (tlp_data),
    .tlp_sop     (tlp_sop),
    .tlp_eop     (tlp_eop),
`ifdef LCRC_NULLIFY_EN
    .tlp_nullify (tlp_nullify),
`endif
    .rb_full     (rb_full),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .next_seq    (next_seq),
    .len_err     (len_err)
  );

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } beat_t;

  int    errors = 0;
  int    checks = 0;
  beat_t q[$];
  beat_t stall_beat;
  bit    stall_pend = 1'b0;
  bit    in_acc;
  bit    lcrc_done;
  int    lenerr_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference LCRC step: shift the register left one bit per data bit,
  // data bit 31 first, xoring the polynomial when the feedback bit is set.
  function automatic logic [31:0] m_step(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 31; b >= 0; b--) begin
      if ((r[31] ^ d[b]) == 1'b1) r = (r << 1) ^ POLY;
      else                        r = r << 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] pat(input logic [31:0] base, input int j);
    return base + (32'(j) * 32'h0101_0101);
  endfunction

  // One clock: sample at the falling edge, then return 1 time unit after the
  // next rising edge so the caller can drive the following cycle.
  task automatic tick();
    @(negedge clk);
    in_acc    = tlp_valid && tlp_ready;
    lcrc_done = out_valid && out_ready && out_eop;
    if (len_err === 1'b1) lenerr_pulses++;
    if (stall_pend) begin
      chk("stall_data", out_data, stall_beat.data);
      chk("stall_flags", {29'b0, out_valid, out_sop, out_eop},
          {29'b0, 1'b1, stall_beat.sop, stall_beat.eop});
    end
    stall_pend = out_valid && !out_ready;
    stall_beat = {out_sop, out_eop, out_data};
    if (out_valid && out_ready) q.push_back({out_sop, out_eop, out_data});
    @(posedge clk);
    #1;
  endtask

  // Drive one TLP of n dwords until its LCRC dword is taken. abort_at >= 0
  // stops driving once that many dwords have been accepted.
  task automatic send_tlp(input int n, input logic [31:0] base, input bit rnd,
                          input bit nul, input int abort_at);
    int j;
    int budget;
    bit done;
    j = 0;
    budget = 300;
    done = 1'b0;
    while (!done && budget > 0) begin
      if (abort_at >= 0 && j == abort_at) begin
        tlp_valid = 1'b0;
        tlp_sop   = 1'b0;
        tlp_eop   = 1'b0;
        return;
      end
      if (j < n) begin
        tlp_valid = 1'b1;
        tlp_data  = pat(base, j);
        tlp_sop   = (j == 0);
        tlp_eop   = (j == n - 1);
      end else begin
        tlp_valid = 1'b0;
        tlp_sop   = 1'b0;
        tlp_eop   = 1'b0;
      end
`ifdef LCRC_NULLIFY_EN
      tlp_nullify = nul;
`endif
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (in_acc && j < n) j++;
      if (lcrc_done) done = 1'b1;
      budget--;
    end
    tlp_valid = 1'b0;
    tlp_sop   = 1'b0;
    tlp_eop   = 1'b0;
    out_ready = 1'b1;
    if (nul && !rnd) begin
      tlp_data = tlp_data;
    end
    chk("frame_done", {31'b0, done}, 32'd1);
  endtask

  task automatic check_frame(input logic [SEQ_W-1:0] seq, input int n,
                             input logic [31:0] base, input bit nul);
    beat_t       b;
    logic [31:0] c;
    logic [31:0] exp_lcrc;
    chk("frame_len", q.size(), n + 2);
    if (q.size() != n + 2) begin
      q.delete();
      return;
    end
    b = q.pop_front();
    chk("hdr_data", b.data, 32'(seq));
    chk("hdr_flags", {30'b0, b.sop, b.eop}, 32'd2);
    c = m_step(INIT, 32'(seq));
    for (int j = 0; j < n; j++) begin
      b = q.pop_front();
      chk("tlp_data", b.data, pat(base, j));
      chk("tlp_flags", {30'b0, b.sop, b.eop}, 32'd0);
      c = m_step(c, pat(base, j));
    end
    b = q.pop_front();
    exp_lcrc = nul ? c : ~c;
    chk("lcrc_data", b.data, exp_lcrc);
    chk("lcrc_flags", {30'b0, b.sop, b.eop}, 32'd1);
    $display("frame seq=%0d dwords=%0d lcrc=%h nullify=%0d", seq, n, exp_lcrc, nul);
  endtask

  initial begin
    reset     = 1'b0;
    tlp_valid = 1'b0;
    tlp_data  = 32'h0;
    tlp_sop   = 1'b0;
    tlp_eop   = 1'b0;
`ifdef LCRC_NULLIFY_EN
    tlp_nullify = 1'b0;
`endif
    rb_full   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_sop",   {31'b0, out_sop},   32'd0);
    chk("rst_out_eop",   {31'b0, out_eop},   32'd0);
    chk("rst_out_data",  out_data,           32'd0);
    chk("rst_tlp_ready", {31'b0, tlp_ready}, 32'd0);
    chk("rst_len_err",   {31'b0, len_err},   32'd0);
    chk("rst_next_seq",  32'(next_seq),      32'd0);
    reset = 1'b1;
    tick();

    // 4-dword TLP, sink always ready
    send_tlp(4, 32'hA000_0010, 1'b0, 1'b0, -1);
    check_frame(12'd0, 4, 32'hA000_0010, 1'b0);
    chk("seq_after_first", 32'(next_seq), 32'd1);

    // Same TLP with a randomly stalling sink
    send_tlp(4, 32'hA000_0010, 1'b1, 1'b0, -1);
    check_frame(12'd1, 4, 32'hA000_0010, 1'b0);
    chk("seq_after_stall", 32'(next_seq), 32'd2);

    // Replay buffer full holds off the header
    rb_full   = 1'b1;
    tlp_valid = 1'b1;
    tlp_sop   = 1'b1;
    tlp_eop   = 1'b0;
    tlp_data  = pat(32'hB000_0000, 0);
    repeat (3) begin
      tick();
      chk("rbfull_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rbfull_tlp_ready", {31'b0, tlp_ready}, 32'd0);
    end
    rb_full = 1'b0;
    tick();
    chk("rbfull_hdr_next", {30'b0, out_valid, out_sop}, 32'd3);
    chk("rbfull_hdr_seq", out_data, 32'd2);
    send_tlp(2, 32'hB000_0000, 1'b0, 1'b0, -1);
    check_frame(12'd2, 2, 32'hB000_0000, 1'b0);

    // Length limit: exactly MAX_DW is fine, one more pulses len_err once
    lenerr_pulses = 0;
    send_tlp(MAX_DW, 32'hC000_0000, 1'b0, 1'b0, -1);
    chk("len_at_max_no_err", lenerr_pulses, 32'd0);
    check_frame(12'd3, MAX_DW, 32'hC000_0000, 1'b0);
    lenerr_pulses = 0;
    send_tlp(MAX_DW + 1, 32'hC100_0000, 1'b0, 1'b0, -1);
    chk("len_over_one_pulse", lenerr_pulses, 32'd1);
    check_frame(12'd4, MAX_DW + 1, 32'hC100_0000, 1'b0);
    chk("seq_after_len", 32'(next_seq), 32'd5);

    // Reset while presenting DATA dword 2
    send_tlp(4, 32'hD000_0000, 1'b0, 1'b0, 2);
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_out_data",  out_data,           32'd0);
    chk("mid_rst_sop_eop",   {30'b0, out_sop, out_eop}, 32'd0);
    chk("mid_rst_tlp_ready", {31'b0, tlp_ready}, 32'd0);
    chk("mid_rst_next_seq",  32'(next_seq),      32'd0);
    tick();
    reset = 1'b1;
    q.delete();
    stall_pend = 1'b0;
    tick();
    send_tlp(1, 32'hD100_0000, 1'b0, 1'b0, -1);
    check_frame(12'd0, 1, 32'hD100_0000, 1'b0);
    chk("seq_after_mid_rst", 32'(next_seq), 32'd1);

`ifdef LCRC_NULLIFY_EN
    // Nullified TLP on seq 5 keeps seq 5 for the next TLP
    for (int s = 1; s <= 4; s++) begin
      send_tlp(1, 32'hE000_0000 + 32'(s), 1'b0, 1'b0, -1);
      check_frame(SEQ_W'(s), 1, 32'hE000_0000 + 32'(s), 1'b0);
    end
    send_tlp(2, 32'hE100_0000, 1'b0, 1'b1, -1);
    check_frame(12'd5, 2, 32'hE100_0000, 1'b1);
    chk("nullify_seq_held", 32'(next_seq), 32'd5);
    send_tlp(2, 32'hE200_0000, 1'b0, 1'b0, -1);
    check_frame(12'd5, 2, 32'hE200_0000, 1'b0);
    chk("seq_after_nullify", 32'(next_seq), 32'd6);
`endif

    // Sequence wrap: 4097 single-dword TLPs from a fresh reset
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int k = 0; k <= 4096; k++) begin
      send_tlp(1, 32'h5000_0000 + 32'(k), 1'b0, 1'b0, -1);
      check_frame(SEQ_W'(k), 1, 32'h5000_0000 + 32'(k), 1'b0);
    end
    chk("seq_after_wrap", 32'(next_seq), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
